// File: rtl/dmem_pkg.sv
// Shared constants, state encoding and address helper for the line-granular data memory.
package dmem_pkg;

    localparam int unsigned LINE_BITS   = 256;
    localparam int unsigned OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StAck  = 2'd2
    } state_e;

    // Full line number; callers keep only the low DEPTH_LOG2 bits, so addresses wrap.
    function automatic logic [31:0] line_index(input logic [31:0] addr);
        return addr >> OFFSET_BITS;
    endfunction

endpackage

// File: rtl/data_memory_array.sv
// Single-port synchronous line RAM, read-first; contents are never reset.
module data_memory_array
    import dmem_pkg::*;
#(
    parameter int unsigned Width   = LINE_BITS,
    parameter int unsigned IdxBits = 9
) (
    input  logic               i_clk,
    input  logic [IdxBits-1:0] i_idx,
    input  logic               i_we,
    input  logic [Width-1:0]   i_wdata,
    output logic [Width-1:0]   o_rdata
);

    logic [Width-1:0] r_mem [2**IdxBits];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
        o_rdata <= r_mem[i_idx];
    end

endmodule

// File: rtl/data_memory.sv
// Fixed-latency line backing store behind the data cache: one outstanding request,
// enable/ack handshake, registered read data.
module data_memory #(
    parameter int unsigned LINE_BITS  = dmem_pkg::LINE_BITS,
    parameter int unsigned DEPTH_LOG2 = 9,
    parameter int unsigned LATENCY    = 10
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [31:0]                    addr_i,
    input  logic [dmem_pkg::LINE_BITS-1:0] data_i,
    input  logic                           enable_i,
    input  logic                           write_i,
    output logic                           ack_o,
    output logic [dmem_pkg::LINE_BITS-1:0] data_o
);
    import dmem_pkg::*;

    localparam logic [7:0] LatM1 = 8'(LATENCY - 1);

    state_e                  r_state;
    logic [7:0]              r_count;
    logic [DEPTH_LOG2-1:0]   r_idx;
    logic                    r_write;
    logic [LINE_BITS-1:0]    r_wdata;
    logic                    r_ack;
    logic [LINE_BITS-1:0]    r_rdata;

    logic [31:0]             w_line;
    logic [DEPTH_LOG2-1:0]   w_addr_idx;
    logic [DEPTH_LOG2-1:0]   w_ram_idx;
    logic                    w_done;
    logic                    w_we;
    logic [LINE_BITS-1:0]    w_ram_rdata;
    logic                    w_unused;

    assign w_line     = line_index(addr_i);
    assign w_addr_idx = w_line[DEPTH_LOG2-1:0];
    assign w_unused   = ^w_line[31:DEPTH_LOG2];

    // The RAM reads the incoming index while idle, then the captured one, so its
    // registered output already holds the line by the completion edge (even at LATENCY=1).
    assign w_ram_idx = (r_state == StIdle) ? w_addr_idx : r_idx;
    assign w_done    = (r_state == StBusy) && (r_count == 8'd0);
    assign w_we      = w_done && r_write;

    data_memory_array #(
        .Width   (LINE_BITS),
        .IdxBits (DEPTH_LOG2)
    ) u_array (
        .i_clk   (clk_i),
        .i_idx   (w_ram_idx),
        .i_we    (w_we),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= StIdle;
            r_count <= 8'd0;
            r_idx   <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (enable_i) begin
                        r_idx   <= w_addr_idx;
                        r_write <= write_i;
                        r_wdata <= data_i;
                        r_count <= LatM1;
                        r_state <= StBusy;
                    end
                end
                StBusy: begin
                    if (r_count == 8'd0) begin
                        r_ack   <= 1'b1;
                        r_state <= StAck;
                        if (!r_write) begin
                            r_rdata <= w_ram_rdata;
                        end
                    end else begin
                        r_count <= r_count - 8'd1;
                    end
                end
                StAck: begin
                    r_ack   <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign ack_o  = r_ack;
    assign data_o = r_rdata;

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Line-granular backing store directly downstream of the data cache controller. It serves 256-bit line reads (refills) and line writes (dirty write-backs).
- Fixed, parameterised access latency; a single-outstanding-request enable/ack handshake.
- Stands in for off-chip DRAM in the CPU system. The cache stalls the pipeline until ack_o is seen.

Parameters:
- LINE_BITS, 256, line width in bits; the fixed 256-bit data ports (data_i, data_o) assume the default value.
- DEPTH_LOG2, 9, log2 of number of lines (512 lines = 16 KiB).
- LATENCY, 10, cycles from request acceptance to ack_o; legal range 1..255.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- addr_i  in  32  byte address; bits [4:0] ignored (line aligned); line index = addr_i[DEPTH_LOG2+4:5].
- data_i  in  256  write line data.
- enable_i  in  1  request valid.
- write_i  in  1  1 = line write, 0 = line read; meaningful only while enable_i=1.
- ack_o  out  1  single-cycle completion pulse.
- data_o  out  256  read line data.

Behaviour:
- Reset (async, rst_i=0):
  - state=IDLE, ack_o=0, data_o=0, latency counter=0, captured request cleared.
  - Array contents are not cleared; they are preloaded by the bench via hierarchical init.
- States:
  - IDLE:
    - enable_i=1 at a rising edge: capture addr_i line index, write_i and data_i; counter <= LATENCY-1; go to BUSY.
    - Otherwise stay in IDLE.
  - BUSY:
    - Counter decrements each edge.
    - At the edge where counter==0: perform the access; ack_o <= 1; go to ACK.
    - Write: array[idx] <= captured data.
    - Read: data_o <= array[idx].
  - ACK:
    - ack_o high for this one cycle; next edge ack_o <= 0, go to IDLE.
    - A request is never accepted while in ACK.
- Latency:
  - Request accepted at edge E0 gives ack_o high during the cycle after edge E0+LATENCY.
  - Next acceptance is possible at edge E0+LATENCY+2, so throughput is one request per LATENCY+2 cycles.
  - LATENCY=1: BUSY lasts exactly one cycle.
- Request capture:
  - Operands are sampled only at acceptance. Changes to addr_i, data_i or write_i during BUSY have no effect.
  - Dropping enable_i during BUSY does not cancel the request: the access completes and ack_o pulses.
- Back-to-back requests:
  - The requester may keep enable_i=1 across ack, e.g. write-back followed by refill, changing addr_i and write_i on the ack edge.
  - The new request is accepted at the first edge in IDLE.
- data_o:
  - Registered; changes only on read completion.
  - Holds its value through later writes and idle periods.
- Write commit: data is visible to any read accepted after the ack edge.
- Addresses beyond the array wrap modulo 2^DEPTH_LOG2; upper bits are ignored silently.
- Reset mid-BUSY aborts the access: no array write, no ack.
- write_i=1 with X data writes X. The bench must flag any X on enable_i or write_i after reset.

Decomposition:
- Package dmem_pkg holds:
  - LINE_BITS and OFFSET_BITS=5;
  - the state encoding (IDLE=2'd0, BUSY=2'd1, ACK=2'd2);
  - the index-extraction helper.
- One natural sub-module: data_memory_array, a single-port synchronous RAM with clk, idx, we, wdata and rdata (read-first). The top holds the FSM, counter and capture registers.

Test Plan:
- Reset then idle: rst_i pulse low, enable_i=0 for 20 cycles → ack_o=0 and data_o=0 throughout.
- Read latency: preload line 3 = {8{32'hDEAD_BEEF}}; read addr 0x60 with LATENCY=10 → ack_o high exactly 11 cycles after the accept edge; data_o equals the preload; ack_o is 1 cycle wide.
- Write then read: write addr 0x0000_0400 with 256'h1234… and await ack; then read 0x0000_0400 → returned data equals the written data; neighbouring line 0x3E0 is unchanged.
- Write-back then refill, enable held:
  - write line 0x2000_0020 (wraps to idx 1), then on the ack edge switch to a read of 0x40 without dropping enable_i;
  - → second ack exactly LATENCY+2 cycles after the first;
  - → idx1 updated, data_o = line 2.
- Operand change mid-BUSY: accept a read of 0x20, then change addr_i to 0x80 and deassert enable_i → data_o = line 1 and exactly one ack.
- Reset mid-operation: accept a write to line 5, assert rst_i at cycle 4 → no ack_o; line 5 keeps its old value; a subsequent read works normally.
